// File: rtl/barrido_display.sv
// ---------------------------------------------------------------------------
// barrido_display
// Display-scan stage for the Booth multiplier board. Divides clk down to the
// digit refresh rate, steps the 3-bit digit-position code read by the anode
// decoder, latches the 5-digit BCD magnitude and sign of the product, and
// drives the registered active-low segment pattern of the selected digit.
//
// Ports:
//   clk                  system clock
//   reset                asynchronous, active-high reset
//   cargar               one-cycle load strobe for bcd_in / signo
//   bcd_in[19:0]         five BCD digits, [3:0] units .. [19:16] ten-thousands
//   signo                1 = product negative
//   contador_actualizar  digit-position code (000,001,010,011,101)
//   segmentos[6:0]       active-low segments, order gfedcba
//   led_negativo         latched sign
//   bcd_invalido         a latched nibble is greater than 9
//
// Build option: define BLANK_CEROS_EN to blank leading zeros (digits 1..4).
//
// state    | meaning
// POS_UNI  | 000: units digit selected
// POS_DEC  | 001: tens digit selected
// POS_CEN  | 010: hundreds digit selected
// POS_MIL  | 011: thousands digit selected
// POS_DMIL | 101: ten-thousands digit selected (code fixed by anode decoder)
// ---------------------------------------------------------------------------
module barrido_display #(
    parameter int FREC_RELOJ    = 100_000_000,
    parameter int FREC_REFRESCO = 10_000,
    parameter int DIV           = FREC_RELOJ / FREC_REFRESCO
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cargar,
    input  logic [19:0] bcd_in,
    input  logic        signo,
    output logic [2:0]  contador_actualizar,
    output logic [6:0]  segmentos,
    output logic        led_negativo,
    output logic        bcd_invalido
);
    localparam int            PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    typedef enum logic [2:0] {
        POS_UNI  = 3'b000,
        POS_DEC  = 3'b001,
        POS_CEN  = 3'b010,
        POS_MIL  = 3'b011,
        POS_DMIL = 3'b101
    } pos_t;

    pos_t          pos;
    pos_t          pos_next;
    logic [PW-1:0] pre;
    logic          tick;
    logic [19:0]   digitos;
    logic          invalido_in;
    logic [3:0]    cero_sup;
    logic [3:0]    digito_sel;
    logic          blanco;
    logic [6:0]    seg_next;

    function automatic logic [6:0] decodificar(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Prescaler: tick is high for the one cycle the count sits at DIV-1.
    assign tick = (pre == PRE_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos <= POS_UNI;
        end else begin
            pos <= pos_next;
        end
    end

    always_comb begin
        pos_next = pos;
        if (tick) begin
            case (pos)
                POS_UNI:  pos_next = POS_DEC;
                POS_DEC:  pos_next = POS_CEN;
                POS_CEN:  pos_next = POS_MIL;
                POS_MIL:  pos_next = POS_DMIL;
                default:  pos_next = POS_UNI;   // POS_DMIL and stray codes
            endcase
        end
    end

    assign contador_actualizar = pos;

    always_comb begin
        invalido_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                invalido_in = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digitos      <= '0;
            led_negativo <= 1'b0;
            bcd_invalido <= 1'b0;
        end else if (cargar) begin
            digitos      <= bcd_in;
            led_negativo <= signo;
            bcd_invalido <= invalido_in;
        end
    end

    // cero_sup[k-1]: digit k and every digit above it are zero.
`ifdef BLANK_CEROS_EN
    assign cero_sup = {digitos[19:16] == 4'd0,
                       digitos[19:12] == 8'd0,
                       digitos[19:8]  == 12'd0,
                       digitos[19:4]  == 16'd0};
`else
    assign cero_sup = 4'b0000;
`endif

    always_comb begin
        digito_sel = 4'hF;      // stray position codes show blank
        blanco     = 1'b0;
        case (pos)
            POS_UNI:  digito_sel = digitos[3:0];
            POS_DEC:  begin digito_sel = digitos[7:4];   blanco = cero_sup[0]; end
            POS_CEN:  begin digito_sel = digitos[11:8];  blanco = cero_sup[1]; end
            POS_MIL:  begin digito_sel = digitos[15:12]; blanco = cero_sup[2]; end
            POS_DMIL: begin digito_sel = digitos[19:16]; blanco = cero_sup[3]; end
            default:  ;
        endcase
        seg_next = blanco ? 7'b1111111 : decodificar(digito_sel);
    end

    // Registered from current position and latched data: one cycle behind
    // both, so a load coinciding with a tick shows the new data at the new
    // position on the following cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            segmentos <= 7'b1000000;
        end else begin
            segmentos <= seg_next;
        end
    end

endmodule
